// File: rtl/rib_mailbox_pkg.sv
// Shared mailbox definitions: bus word types, register offsets (addr[3:2]),
// STATUS/CTRL bit positions, default FIFO depth and the access FSM encoding.
package rib_mailbox_pkg;

  localparam int MBOX_DEPTH = 8;

  typedef logic [31:0] mem_bus_t;
  typedef logic [31:0] mem_addr_bus_t;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_TX_CNT_LSB = 0;
  localparam int ST_RX_CNT_LSB = 4;
  localparam int ST_TX_FULL    = 8;
  localparam int ST_RX_EMPTY   = 9;
  localparam int ST_TX_OVF     = 10;
  localparam int ST_RX_UDF     = 11;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } acc_state_t;

endpackage

// File: rtl/rib_mailbox_fifo.sv
// mbox_fifo: synchronous 32-bit FIFO, DEPTH entries (power of two).
// Ports: push/wdata write side, pop read side, head = current oldest word,
// count = occupancy (0..DEPTH), full/empty flags. Push when full and pop when
// empty are ignored. Storage is cleared by reset.
module mbox_fifo
  import rib_mailbox_pkg::*;
#(
  parameter int DEPTH = MBOX_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  mem_bus_t                 wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output mem_bus_t                 head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  mem_bus_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rib_mailbox.sv
// rib_mailbox: RIB slave mailbox. CPU writes TXDATA to feed the TX stream,
// reads RXDATA to drain the RX stream; STATUS/CTRL for polling and interrupts.
// Ports: clk/rst; RIB slave req_i/we_i/addr_i/data_i -> data_o/ready_o;
// TX stream tx_valid_o/tx_data_o/tx_ready_i; RX stream rx_valid_i/rx_data_i/
// rx_ready_o; level interrupt int_o.
module rib_mailbox
  import rib_mailbox_pkg::*;
#(
  parameter int DEPTH = MBOX_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic          we_i,
  input  mem_addr_bus_t addr_i,
  input  mem_bus_t      data_i,
  output mem_bus_t      data_o,
  output logic          ready_o,
  output logic          tx_valid_o,
  output mem_bus_t      tx_data_o,
  input  logic          tx_ready_i,
  input  logic          rx_valid_i,
  input  mem_bus_t      rx_data_i,
  output logic          rx_ready_o,
  output logic          int_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  acc_state_t      state, state_nxt;
  logic            accept;
  logic [1:0]      sel;
  logic            tx_push, tx_pop, rx_push, rx_pop;
  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]   tx_cnt, rx_cnt;
  mem_bus_t        tx_head, rx_head;
  logic            tx_ovf, rx_udf, rx_ie, tx_ie;
  mem_bus_t        status, rd_val, rdata_q;
  logic            unused_addr;

  assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

  assign sel     = addr_i[3:2];
  assign accept  = (state == S_IDLE) & req_i;
  assign tx_push = accept & we_i & (sel == REG_TXDATA);
  assign rx_pop  = accept & ~we_i & (sel == REG_RXDATA);
  assign tx_pop  = tx_ready_i & ~tx_empty;
  assign rx_push = rx_valid_i & ~rx_full;

  mbox_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .wdata (data_i),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_cnt),
    .head  (tx_head)
  );

  mbox_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_data_i),
    .pop   (rx_pop),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_cnt),
    .head  (rx_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_i) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    status                        = '0;
    status[ST_TX_CNT_LSB +: 4]    = 4'(tx_cnt);
    status[ST_RX_CNT_LSB +: 4]    = 4'(rx_cnt);
    status[ST_TX_FULL]            = tx_full;
    status[ST_RX_EMPTY]           = rx_empty;
    status[ST_TX_OVF]             = tx_ovf;
    status[ST_RX_UDF]             = rx_udf;
  end

  // Read value is formed from pre-edge state, so STATUS reflects the
  // moment of acceptance, not that edge's pushes/pops.
  always_comb begin
    rd_val = '0;
    if (!we_i) begin
      case (sel)
        REG_RXDATA: rd_val = rx_empty ? '0 : rx_head;
        REG_STATUS: rd_val = status;
        REG_CTRL: begin
          rd_val[CTRL_RX_IE] = rx_ie;
          rd_val[CTRL_TX_IE] = tx_ie;
        end
        default:    rd_val = '0;
      endcase
    end
  end

  // rdata_q is only non-zero during RESP: it is loaded on acceptance and
  // cleared on every other edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      tx_ovf  <= 1'b0;
      rx_udf  <= 1'b0;
      rx_ie   <= 1'b0;
      tx_ie   <= 1'b0;
    end else begin
      rdata_q <= accept ? rd_val : '0;
      if (tx_push & tx_full)  tx_ovf <= 1'b1;
      if (rx_pop & rx_empty)  rx_udf <= 1'b1;
      if (accept & we_i & (sel == REG_STATUS)) begin
        if (data_i[ST_TX_OVF]) tx_ovf <= 1'b0;
        if (data_i[ST_RX_UDF]) rx_udf <= 1'b0;
      end
      if (accept & we_i & (sel == REG_CTRL)) begin
        rx_ie <= data_i[CTRL_RX_IE];
        tx_ie <= data_i[CTRL_TX_IE];
      end
    end
  end

  assign ready_o    = (state == S_RESP);
  assign data_o     = rdata_q;
  assign tx_valid_o = ~tx_empty;
  assign tx_data_o  = tx_head;
  assign rx_ready_o = ~rx_full;
  assign int_o      = (rx_ie & ~rx_empty) | (tx_ie & tx_empty);

endmodule

// File: tb/tb_rib_mailbox.sv
// Self-checking bench for rib_mailbox: directed steps followed by random
// traffic, compared every cycle against a queue-based mailbox model.
module tb_rib_mailbox;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0, we_i = 1'b0;
  logic [31:0] addr_i = '0, data_i = '0;
  logic [31:0] data_o;
  logic        ready_o;
  logic        tx_valid_o;
  logic [31:0] tx_data_o;
  logic        tx_ready_i = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [31:0] rx_data_i = '0;
  logic        rx_ready_o;
  logic        int_o;

  rib_mailbox #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .ready_o    (ready_o),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .tx_ready_i (tx_ready_i),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .rx_ready_o (rx_ready_o),
    .int_o      (int_o)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Mailbox model: two word queues, sticky flags, enables, and whether the
  // slave is in its response cycle.
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  bit          m_ovf, m_udf, m_rxie, m_txie, m_resp;
  logic [31:0] m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nvec++;
    assert (obs === exp_v)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_ovf = 0; m_udf = 0; m_rxie = 0; m_txie = 0; m_resp = 0;
    m_rdata = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},    {31'd0, ready_o},    32'd0);
    chk({tag, "_data"},     data_o,              32'd0);
    chk({tag, "_txvalid"},  {31'd0, tx_valid_o}, 32'd0);
    chk({tag, "_txdata"},   tx_data_o,           32'd0);
    chk({tag, "_rxready"},  {31'd0, rx_ready_o}, 32'd1);
    chk({tag, "_int"},      {31'd0, int_o},      32'd0);
  endtask

  // One clock: apply the model's rules for the currently driven inputs,
  // step the clock, then compare all visible outputs.
  task automatic tick();
    bit          acc, do_txpush, do_rxpop, tx_pop, rx_push;
    int          txn, rxn;
    logic [31:0] rv;
    txn = txq.size();
    rxn = rxq.size();
    tx_pop    = tx_ready_i && (txn > 0);
    rx_push   = rx_valid_i && (rxn < DEPTH);
    acc       = req_i && !m_resp;
    do_txpush = 0;
    do_rxpop  = 0;
    rv        = '0;
    if (acc) begin
      case (addr_i[3:2])
        2'd0: if (we_i) begin
          if (txn == DEPTH) m_ovf = 1; else do_txpush = 1;
        end
        2'd1: if (!we_i) begin
          if (rxn == 0) m_udf = 1;
          else begin rv = rxq[0]; do_rxpop = 1; end
        end
        2'd2: if (we_i) begin
          if (data_i[10]) m_ovf = 0;
          if (data_i[11]) m_udf = 0;
        end else begin
          rv = {20'd0, m_udf, m_ovf, rxn == 0, txn == DEPTH, 4'(rxn), 4'(txn)};
        end
        default: if (we_i) {m_txie, m_rxie} = data_i[1:0];
                 else rv = {30'd0, m_txie, m_rxie};
      endcase
    end
    if (tx_pop)    void'(txq.pop_front());
    if (do_txpush) txq.push_back(data_i);
    if (do_rxpop)  void'(rxq.pop_front());
    if (rx_push)   rxq.push_back(rx_data_i);
    m_resp  = acc;
    m_rdata = rv;
    @(posedge clk);
    #1;
    chk("ready",   {31'd0, ready_o},    {31'd0, m_resp});
    chk("rdata",   data_o,              m_resp ? m_rdata : 32'd0);
    chk("txvalid", {31'd0, tx_valid_o}, {31'd0, txq.size() > 0});
    if (txq.size() > 0) chk("txdata", tx_data_o, txq[0]);
    chk("rxready", {31'd0, rx_ready_o}, {31'd0, rxq.size() < DEPTH});
    chk("int",     {31'd0, int_o},
        {31'd0, (m_rxie && rxq.size() > 0) || (m_txie && txq.size() == 0)});
  endtask

  // Bus accesses put random junk in the undecoded address bits.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    req_i = 1; we_i = 1; addr_i = a | ($urandom & 32'hFFFF_FFF3); data_i = d;
    tick();
    req_i = 0; we_i = 0;
    tick();
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    req_i = 1; we_i = 0; addr_i = a | ($urandom & 32'hFFFF_FFF3);
    tick();
    d = data_o;
    req_i = 0;
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    model_reset();
    #3;
    chk_reset_outputs("por");
    @(posedge clk); #1;
    rst = 0;

    // Status after reset: only rx_empty set.
    bus_rd(32'h8, rd);
    chk("status_after_reset", rd, 32'h200);

    // Two TX words, then drain in order.
    bus_wr(32'h0, 32'hDEADBEEF);
    bus_wr(32'h0, 32'h12345678);
    chk("tx_head_first", tx_data_o, 32'hDEADBEEF);
    bus_rd(32'h8, rd);
    chk("status_tx2", rd, 32'h202);
    tx_ready_i = 1;
    tick();
    chk("tx_head_second", tx_data_o, 32'h12345678);
    tick();
    chk("tx_drained", {31'd0, tx_valid_o}, 32'd0);
    tx_ready_i = 0;

    // Overflow: 9th word dropped, sticky set, then W1C.
    for (int i = 0; i < 9; i++) bus_wr(32'h0, 32'h100 + i);
    bus_rd(32'h8, rd);
    chk("status_tx_ovf", rd, 32'h708);
    bus_wr(32'h8, 32'h400);
    bus_rd(32'h8, rd);
    chk("status_ovf_clr", rd, 32'h308);
    tx_ready_i = 1;
    for (int i = 0; i < 8; i++) begin
      chk("tx_order", tx_data_o, 32'h100 + i);
      tick();
    end
    chk("tx_no_9th", {31'd0, tx_valid_o}, 32'd0);
    tx_ready_i = 0;

    // RX underflow, then one streamed word.
    bus_rd(32'h4, rd);
    chk("rx_udf_data", rd, 32'd0);
    bus_rd(32'h8, rd);
    chk("status_rx_udf", rd, 32'hA00);
    rx_valid_i = 1; rx_data_i = 32'hA5A5A5A5;
    tick();
    rx_valid_i = 0;
    bus_rd(32'h4, rd);
    chk("rx_pop_word", rd, 32'hA5A5A5A5);
    bus_rd(32'h8, rd);
    chk("status_rx_back0", rd, 32'hA00);
    bus_wr(32'h8, 32'h800);

    // RX interrupt.
    bus_wr(32'hC, 32'h1);
    bus_rd(32'hC, rd);
    chk("ctrl_readback", rd, 32'h1);
    rx_valid_i = 1; rx_data_i = 32'h11;
    tick();
    rx_valid_i = 0;
    chk("int_rx_set", {31'd0, int_o}, 32'd1);
    req_i = 1; we_i = 0; addr_i = 32'h4;
    tick();
    chk("int_rx_clr", {31'd0, int_o}, 32'd0);
    req_i = 0;
    tick();
    bus_wr(32'hC, 32'h0);

    // Fill RX while a TX stream pop and a TX push share one edge.
    bus_wr(32'h0, 32'h77);
    rx_valid_i = 1; rx_data_i = $urandom;
    tx_ready_i = 1;
    req_i = 1; we_i = 1; addr_i = 32'h0; data_i = 32'h88;
    tick();
    tx_ready_i = 0; req_i = 0; we_i = 0;
    rx_data_i = $urandom;
    tick();
    for (int i = 0; i < 7; i++) begin
      rx_data_i = $urandom;
      tick();
    end
    rx_valid_i = 0;
    chk("rx_full_ready", {31'd0, rx_ready_o}, 32'd0);
    chk("tx_same_edge_head", tx_data_o, 32'h88);
    bus_rd(32'h8, rd);
    chk("status_rx_full", rd, 32'h81);

    // Reset mid-access: accepted, then reset during the response cycle.
    req_i = 1; we_i = 0; addr_i = 32'h8;
    tick();
    rst = 1;
    #1;
    model_reset();
    chk_reset_outputs("rst_mid");
    req_i = 0;
    @(posedge clk); #1;
    chk_reset_outputs("rst_hold");
    rst = 0;
    bus_rd(32'h8, rd);
    chk("status_after_mid_rst", rd, 32'h200);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      req_i      = ($urandom_range(0, 2) != 0);
      we_i       = $urandom_range(0, 1);
      addr_i     = $urandom;
      data_i     = $urandom;
      tx_ready_i = ($urandom_range(0, 3) == 0);
      rx_valid_i = ($urandom_range(0, 2) == 0);
      rx_data_i  = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rib_mailbox.md
# rib_mailbox

RIB slave-side mailbox: the responder for core/debug-master accesses, mapped into a free slave slot using the req/ready slave handshake. A CPU write to TXDATA pushes a word into an 8-deep TX FIFO, which an external stream consumer drains. An external stream producer fills an RX FIFO, which the CPU pops by reading RXDATA. Status and interrupt logic let firmware poll or take an interrupt.

## Interface
- DEPTH, 8, entries per FIFO; legal values 2, 4, 8.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  1  RIB slave request; held by the bus until ready_o.
- we_i  in  1  1 = write, 0 = read; qualified by req_i.
- addr_i  in  32  byte address; only addr_i[3:2] decoded.
- data_i  in  32  write data.
- data_o  out  32  read data; valid only while ready_o=1, else 0.
- ready_o  out  1  one-cycle access-complete strobe.
- tx_valid_o  out  1  TX FIFO non-empty.
- tx_data_o  out  32  TX FIFO head word.
- tx_ready_i  in  1  consumer accepts head when tx_valid_o & tx_ready_i.
- rx_valid_i  in  1  producer word valid.
- rx_data_i  in  32  producer word.
- rx_ready_o  out  1  equals ~rx_full.
- int_o  out  1  level interrupt.

## Operation
- Register map (addr_i[3:2]):
  - 0 TXDATA: write pushes data_i; read returns 0.
  - 1 RXDATA: read pops and returns head; write is ignored.
  - 2 STATUS: [3:0] tx_cnt, [7:4] rx_cnt, [8] tx_full, [9] rx_empty, [10] tx_ovf, [11] rx_udf, rest 0. Writing 1 to bit 10/11 clears it.
  - 3 CTRL: RW, [0] rx_ie, [1] tx_ie, rest read 0.
- Access FSM, IDLE -> RESP -> IDLE:
  - IDLE with req_i=1: accept; all side effects (push, pop, W1C, CTRL write) occur on this edge; go to RESP.
  - RESP: ready_o=1, data_o holds the registered read value; always return to IDLE.
  - req_i still high in IDLE after RESP is a new access.
- TXDATA write when tx_full: word is dropped and tx_ovf is set. Fullness is judged on pre-edge count, even if a stream pop happens on the same edge.
- RXDATA read when rx_empty: returns 0, FIFO unchanged, rx_udf is set.
- Simultaneous push and pop on one FIFO (both legal): both occur, count unchanged, pointers wrap modulo DEPTH.
- A stream pop and a RIB push on the same edge are independent.
- int_o = (rx_ie & ~rx_empty) | (tx_ie & ~tx_valid_o), computed from flops only.

## Timing
- Reset values:
  - FSM = IDLE.
  - ready_o=0, data_o=0, tx_valid_o=0, tx_data_o=0 (storage cleared).
  - rx_ready_o=1, int_o=0.
  - Counts, pointers, sticky bits and CTRL all 0.
- RIB access latency: ready_o is high in the cycle after acceptance; 2 cycles per access minimum.
- RIB push to tx_valid_o=1: visible in the cycle after acceptance (same cycle as ready_o).
- RX stream word accepted on edge with rx_valid_i & rx_ready_o; visible in STATUS rx_cnt on the next access.
- A STATUS read returns values sampled at acceptance, before that edge's updates.
- Reset asserted mid-access: FSM returns to IDLE immediately, no ready_o pulse, FIFO contents lost.

## Structure
- Address offsets, STATUS/CTRL bit positions and MBOX_DEPTH default go in the shared defines header, next to MemBus/MemAddrBus.
- Sub-module mbox_fifo (synchronous FIFO with DEPTH parameter, 32-bit data):
  - Ports: push, pop, full, empty, count, head.
  - Instantiated twice, for TX and RX.
- rib_mailbox holds the access FSM, register decode, sticky bits, CTRL and the interrupt.

## Test plan
- Reset, then read STATUS -> ready_o one cycle after req; data_o=0x200 (rx_empty only); tx_valid_o=0; rx_ready_o=1.
- Write 0xDEADBEEF and 0x12345678 to TXDATA with tx_ready_i=0 -> tx_cnt=2, tx_data_o=0xDEADBEEF. Raise tx_ready_i -> words leave in order, tx_valid_o drops after 2 cycles.
- 9 TXDATA writes with tx_ready_i=0 -> tx_cnt=8, tx_full=1, tx_ovf=1, 9th word absent. Write 0x400 to STATUS -> tx_ovf=0.
- Read RXDATA when empty -> data_o=0, rx_udf=1. Stream in 0xA5A5A5A5 -> next RXDATA read returns it, rx_cnt back to 0.
- Set CTRL=1, stream one RX word -> int_o=1 the cycle after acceptance. Pop via RXDATA -> int_o=0 after the pop edge.
- Fill RX to 8 while streaming a TX pop and a RIB TX push on the same edge -> rx_ready_o=0, tx_cnt unchanged. Assert rst mid-access -> no ready_o, all outputs at reset values.
